// File: rtl/pht_gshare_mc.sv
// Multi-channel gshare pattern history table with init/flush sequencing and a
// registered read-modify-write update pipeline that bypasses into reads and updates.
module pht_gshare_mc #(
   parameter int XLEN      = 64,
   parameter int PHT_SIZE  = 64,
   parameter int CHANNELS  = 4,
   parameter int CTR_WIDTH = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   output logic                ready_o,
   input  logic [XLEN-1:0]     rd_pc_i,
   output logic [CHANNELS-1:0] rd_pred_o,
   input  logic                upd_valid_i,
   input  logic [XLEN-1:0]     upd_pc_i,
   input  logic                upd_taken_i
);
   localparam int IDX_W = $clog2(PHT_SIZE);
   localparam int CH_W  = $clog2(CHANNELS);
   localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH-1)) - 1);
   localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
   localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(PHT_SIZE - 1);

   typedef enum logic {ST_INIT, ST_READY} state_e;

   typedef struct packed {
      logic                 vld;
      logic [CH_W-1:0]      ch;
      logic [IDX_W-1:0]     idx;
      logic [CTR_WIDTH-1:0] ctr;
   } upd_s_t;

   state_e                         state_q, state_d;
   logic [IDX_W-1:0]               init_cnt_q, init_cnt_d;
   logic [CHANNELS-1:0][IDX_W-1:0] ghr_q, ghr_d;
   upd_s_t                         s1_q, s1_d;
   logic [CTR_WIDTH-1:0]           tbl_q [CHANNELS][PHT_SIZE];

   logic                 init_we, s1_we;
   logic [CH_W-1:0]      u_ch;
   logic [IDX_W-1:0]     u_idx, rd_base;
   logic [CTR_WIDTH-1:0] u_old, u_new;
   logic                 unused_pc;

   assign ready_o   = (state_q == ST_READY);
   assign rd_base   = rd_pc_i[CH_W+IDX_W+1:CH_W+2];
   assign unused_pc = ^{rd_pc_i[XLEN-1:CH_W+IDX_W+2], rd_pc_i[1:0],
                        upd_pc_i[XLEN-1:CH_W+IDX_W+2], upd_pc_i[1:0]};

   // Read port: the pending stage-1 value wins over the array (write-through).
   for (genvar c = 0; c < CHANNELS; c++) begin : g_rd
      logic [IDX_W-1:0]     idx;
      logic [CTR_WIDTH-1:0] ctr;
      assign idx = rd_base ^ ghr_q[c];
      assign ctr = (s1_q.vld && s1_q.ch == CH_W'(c) && s1_q.idx == idx) ? s1_q.ctr
                                                                         : tbl_q[c][idx];
      assign rd_pred_o[c] = ready_o & ctr[CTR_WIDTH-1];
   end

   assign u_ch  = upd_pc_i[CH_W+1:2];
   assign u_idx = upd_pc_i[CH_W+IDX_W+1:CH_W+2] ^ ghr_q[u_ch];
   assign u_old = (s1_q.vld && s1_q.ch == u_ch && s1_q.idx == u_idx) ? s1_q.ctr
                                                                     : tbl_q[u_ch][u_idx];

   always_comb begin
      u_new = u_old;
      if (upd_taken_i) begin
         if (u_old != CTR_MAX) u_new = u_old + CTR_ONE;
      end else if (u_old != '0) begin
         u_new = u_old - CTR_ONE;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      ghr_d      = ghr_q;
      s1_d       = '0;
      init_we    = 1'b0;
      case (state_q)
         ST_INIT: begin
            init_we    = 1'b1;
            init_cnt_d = init_cnt_q + IDX_W'(1);
            if (init_cnt_q == IDX_LAST) state_d = ST_READY;
         end
         ST_READY: begin
            if (upd_valid_i) begin
               s1_d         = '{vld: 1'b1, ch: u_ch, idx: u_idx, ctr: u_new};
               ghr_d[u_ch]  = {ghr_q[u_ch][IDX_W-2:0], upd_taken_i};
            end
         end
         default: state_d = ST_INIT;
      endcase
      // Flush drops both the same-cycle update and any pending stage-1 write.
      if (flush_i) begin
         state_d    = ST_INIT;
         init_cnt_d = '0;
         ghr_d      = '0;
         s1_d       = '0;
         init_we    = 1'b0;
      end
   end

   assign s1_we = s1_q.vld & ~flush_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
         ghr_q      <= '0;
         s1_q       <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         ghr_q      <= ghr_d;
         s1_q       <= s1_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         if (init_we) begin
            for (int c = 0; c < CHANNELS; c++) tbl_q[c][init_cnt_q] <= CTR_INIT;
         end
         if (s1_we) tbl_q[s1_q.ch][s1_q.idx] <= s1_q.ctr;
      end
   end
endmodule

// File: doc/pht_gshare_mc.md
Name: pht_gshare_mc

Overview:
- Parametrised, multi-channel gshare pattern history table. Successor to the fixed 4-channel, 2-bit PHT in instr_front.
- Generalises channel count, counter width and table depth.
- Adds:
  - a post-reset / flush table-initialisation FSM,
  - a registered read-modify-write update pipeline with same-entry bypass,
  - a ready indication.
- Sits in the fetch front end beside the BTB: fetch reads predictions combinationally; the branch resolve path issues updates.

Parameters:
- XLEN, 64, PC width.
- PHT_SIZE, 64, entries per channel; power of two, ≥4.
- CHANNELS, 4, number of channels (power of two, ≥2); one GHR and one table per channel.
- CTR_WIDTH, 2, saturating counter width (≥2).
- Derived, not overridable:
  - IDX_W = $clog2(PHT_SIZE)
  - CH_W = $clog2(CHANNELS)
  - CTR_INIT = 2^(CTR_WIDTH-1)-1 (weakly not-taken)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- flush_i  in  1  clear all GHRs and re-initialise the table
- ready_o  out  1  table initialised; updates accepted, predictions valid
- rd_pc_i  in  XLEN  fetch PC
- rd_pred_o  out  CHANNELS  per-channel taken prediction
- upd_valid_i  in  1  branch resolve update strobe
- upd_pc_i  in  XLEN  resolved branch PC
- upd_taken_i  in  1  resolved direction

Behaviour:
- One clock, clk_i. Reset is synchronous, active-low on rst_ni; all state changes on the rising edge of clk_i.
- Address fields:
  - channel = pc[CH_W+1:2]
  - base index = pc[CH_W+IDX_W+1:CH_W+2]
  - entry index = base ^ GHR[channel]
  - All GHRs are IDX_W bits.
- Read (combinational):
  - rd_pred_o[c] = MSB of counter at (c, base(rd_pc_i) ^ GHR[c]).
  - Forced 0 while ready_o=0.
  - If the stage-1 pending write targets the same (c, index), return the pending new value (write-through bypass).
- Reset (rst_ni=0):
  - FSM=INIT, init counter=0, all GHRs=0, stage-1 valid=0, ready_o=0, rd_pred_o=0.
- FSM INIT:
  - Each cycle writes CTR_INIT to entry init_cnt in every channel, then init_cnt++.
  - When init_cnt==PHT_SIZE-1 is written, go to READY.
  - ready_o rises exactly PHT_SIZE cycles after the first cycle with rst_ni=1.
  - upd_valid_i is ignored in INIT; no GHR change, no write.
- FSM READY: ready_o=1; updates processed.
- flush_i=1 (any state):
  - Next cycle: GHRs=0, stage-1 valid=0, init_cnt=0, FSM=INIT.
  - A pending stage-1 write is dropped.
  - A same-cycle update is dropped.
  - Flush during INIT restarts from 0.
  - Reset has priority over flush.
- Update stage 0 (upd_valid_i & READY & !flush_i):
  - Compute ch and idx using the pre-shift GHR[ch].
  - old = counter value, or stage-1 new value if stage 1 is valid with the same ch/idx (bypass).
  - new = sat_inc(old) if taken, else sat_dec(old). Saturating at 2^CTR_WIDTH-1 and 0.
  - Register {ch, idx, new} into stage 1.
  - GHR[ch] <= {GHR[ch][IDX_W-2:0], upd_taken_i} at the same edge.
- Update stage 1: writes new to (ch, idx) one cycle later.
  - Write index is the stage-0 index (pre-shift GHR), never the shifted one.
- Back-to-back updates are accepted every cycle; there is no backpressure.
- A read and an update in the same cycle are independent; the read sees pre-update GHRs.

Test Plan:
- Release reset at cycle 0, default params → ready_o=0 and rd_pred_o=4'b0 for cycles 0–63, ready_o=1 at cycle 64; every entry of every channel reads 2'b01.
- After ready, update pc=0x10 taken (ch0, base 1, GHR0=0, entry 1: 01→10); next cycle GHR0=6'b000001; then read pc=0x00 → entry 0^1=1 → rd_pred_o[0]=1.
- Back-to-back bypass: update pc=0x10 taken, next cycle update pc=0x00 taken (base 0 ^ GHR0=1 → entry 1) → entry 1 ends at 2'b11, not 2'b10; GHR0=6'b000011.
- Saturation: 5 taken updates to one entry (GHR compensated by PC choice) → stays 2'b11; then 5 not-taken → 2'b00, never wraps. Repeat with CTR_WIDTH=3: init 3'b011, saturates at 3'b111 and 3'b000.
- Flush mid-operation: after training, assert flush_i together with an update → the update is dropped, all GHRs=0, ready_o=0 for 64 cycles, all counters return to CTR_INIT. Flush again at init cycle 30 → ready_o is delayed to 64 cycles after the second flush.
- Channel isolation, CHANNELS=8: update pc=0x1C (ch7) → only GHR7 and ch7 table change; rd_pred_o[6:0] unchanged. Reset pulse mid-INIT → init_cnt restarts and ready_o stays 0.
